multiplication: RTL and testbench

Sequential 32x32 shift-add multiply-accumulate unit, P = A*B + C, producing a 64-bit result. It is the inverse companion to the ALU's sequential divider. Given a divider's quotient D, divisor B and remainder R, it reconstructs the dividend A = D*B + R, so it serves both as the ALU multiply path and as the divide self-check. It uses the same start/ok/err handshake style as the divider.

---
 rtl/multiplication.sv | 103 ++++++++++
 tb/tb_multiplication.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/multiplication.sv
// Sequential 32x32 shift-add multiply-accumulate: P = A*B + C over 32 cycles.
// It also reconstructs a divider's dividend from its quotient, divisor and remainder.
module multiplication (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] C,
  output logic [63:0] P,
  output logic        ok,
  output logic        err,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: start is taken at a rising edge only in IDLE or DONE; ok then
  // drops until the result edge 32 cycles later, and stays high with P/err
  // stable until the next accepted start. start during RUN is dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] mcand, mcand_n;
  logic [63:0] acc, acc_n;
  logic [31:0] mplier, mplier_n;
  logic [4:0]  cnt, cnt_n;
  logic [63:0] p_n;
  logic        ok_n, err_n, busy_n;
  logic [63:0] sum;

  assign sum       = acc + (mplier[0] ? mcand : 64'd0);
  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    acc_n    = acc;
    mplier_n = mplier;
    cnt_n    = cnt;
    p_n      = P;
    ok_n     = ok;
    err_n    = err;
    busy_n   = busy;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          mcand_n  = {32'd0, A};
          mplier_n = B;
          acc_n    = {32'd0, C};
          cnt_n    = 5'd0;
          busy_n   = 1'b1;
          ok_n     = 1'b0;
          err_n    = 1'b0;
          state_n  = RUN;
        end
      end
      RUN: begin
        acc_n    = sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 5'd1;
        // P is only updated here so partial sums never become visible.
        if (cnt == 5'd31) begin
          p_n     = sum;
          err_n   = |sum[63:32];
          ok_n    = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= 64'd0;
      acc    <= 64'd0;
      mplier <= 32'd0;
      cnt    <= 5'd0;
      P      <= 64'd0;
      ok     <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      acc    <= acc_n;
      mplier <= mplier_n;
      cnt    <= cnt_n;
      P      <= p_n;
      ok     <= ok_n;
      err    <= err_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for the multiply-accumulate unit: hand-computed products,
// overflow flag, start-during-run, and reset interaction.
module tb_multiplication;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A, B, C;
  logic [63:0] P;
  logic        ok, err, busy;
  logic [1:0]  state_dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last_p;

  multiplication dut (
    .clk(clk), .reset(reset), .start(start),
    .A(A), .B(B), .C(C),
    .P(P), .ok(ok), .err(err), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept one operation and follow it to its result edge, checking the
  // busy/ok window and that P holds the previous result while running.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [63:0] exp_p, input logic exp_err, input string tag);
    A = a; B = b; C = c; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy@accept"}, 64'(busy), 64'd1);
    check({tag, " ok@accept"}, 64'(ok), 64'd0);
    check({tag, " state@accept"}, 64'(state_dbg), 64'd1);
    for (int i = 1; i < 32; i++) begin
      tick();
      check({tag, " busy run"}, 64'(busy), 64'd1);
      if (i == 16) check({tag, " P held mid-run"}, P, last_p);
    end
    check({tag, " ok before k+32"}, 64'(ok), 64'd0);
    tick();
    check({tag, " ok"}, 64'(ok), 64'd1);
    check({tag, " busy done"}, 64'(busy), 64'd0);
    check({tag, " P"}, P, exp_p);
    check({tag, " err"}, 64'(err), 64'(exp_err));
    check({tag, " state done"}, 64'(state_dbg), 64'd2);
    last_p = exp_p;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; A = '0; B = '0; C = '0;
    last_p = 64'd0;
    tick();
    tick();
    check("reset P", P, 64'd0);
    check("reset ok", 64'(ok), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);
    reset = 1'b1;
    tick();

    // Divider reconstruction: 20*50 + 23, then hold with no start.
    run_op(32'd20, 32'd50, 32'd23, 64'd1023, 1'b0, "recon");
    for (int i = 0; i < 200; i++) tick();
    check("recon hold ok", 64'(ok), 64'd1);
    check("recon hold P", P, 64'd1023);
    check("recon hold err", 64'(err), 64'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1, "max");
    run_op(32'd0, 32'hDEAD_BEEF, 32'd7, 64'd7, 1'b0, "zeroA");
    run_op(32'h1_0000, 32'h1_0000, 32'd0, 64'h1_0000_0000, 1'b1, "2^32");

    // Start during RUN is ignored.
    tick();
    A = 32'd3; B = 32'd5; C = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    A = 32'd9; B = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored start busy", 64'(busy), 64'd1);
    for (int i = 11; i < 32; i++) tick();
    check("ignored start ok early", 64'(ok), 64'd0);
    tick();
    check("ignored start ok", 64'(ok), 64'd1);
    check("ignored start P", P, 64'd15);
    last_p = 64'd15;
    tick();
    run_op(32'd9, 32'd9, 32'd0, 64'd81, 1'b0, "reissue");

    // Reset mid-operation abandons the result.
    A = 32'd1000; B = 32'd1000; C = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset P", P, 64'd0);
    check("midreset ok", 64'(ok), 64'd0);
    check("midreset err", 64'(err), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    check("midreset ok later", 64'(ok), 64'd0);
    check("midreset state", 64'(state_dbg), 64'd0);
    last_p = 64'd0;
    run_op(32'd1000, 32'd1000, 32'd0, 64'd1_000_000, 1'b0, "after reset");

    // Reset wins over start; releasing reset with start high accepts.
    reset = 1'b0; start = 1'b1;
    tick();
    check("reset+start busy", 64'(busy), 64'd0);
    check("reset+start state", 64'(state_dbg), 64'd0);
    last_p = 64'd0;
    reset = 1'b1;
    run_op(32'd7, 32'd6, 32'd1, 64'd43, 1'b0, "release+start");

    // Start held high in DONE re-accepts immediately.
    A = 32'd2; B = 32'd3; C = 32'd4; start = 1'b1;
    tick();
    check("reaccept busy", 64'(busy), 64'd1);
    check("reaccept ok", 64'(ok), 64'd0);
    for (int i = 1; i < 33; i++) tick();
    check("reaccept P", P, 64'd10);
    check("reaccept ok done", 64'(ok), 64'd1);
    tick();
    check("reaccept again busy", 64'(busy), 64'd1);
    check("reaccept again ok", 64'(ok), 64'd0);
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
